// File: rtl/cache_controller_pkg.sv
// cache_controller_pkg: shared geometry, base address and FSM state encoding for the data cache
package cache_controller_pkg;
    localparam int          SET_BITS  = 6;
    localparam int          TAG_BITS  = 11;
    localparam int          SETS      = 1 << SET_BITS;
    localparam logic [31:0] BASE_ADDR = 32'd1024;
    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;
endpackage

// File: rtl/cache_way.sv
// cache_way: one way of the data cache (valid/tag/data per set), async read, sync write
// Ports: clk, rst (async active-low, clears valid bits only), we/idx/wtag/wdata write port,
//        valid/tag/data async read of set idx.
module cache_way
    import cache_controller_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [SET_BITS-1:0] idx,
    input  logic [TAG_BITS-1:0] wtag,
    input  logic [31:0]         wdata,
    output logic                valid,
    output logic [TAG_BITS-1:0] tag,
    output logic [31:0]         data
);
    logic [SETS-1:0]     valid_q;
    logic [TAG_BITS-1:0] tag_q  [SETS];
    logic [31:0]         data_q [SETS];

    always_ff @(posedge clk or negedge rst)
        if (!rst) valid_q <= '0;
        else if (we) valid_q[idx] <= 1'b1;

    always_ff @(posedge clk)
        if (we) begin
            tag_q[idx]  <= wtag;
            data_q[idx] <= wdata;
        end

    assign valid = valid_q[idx];
    assign tag   = tag_q[idx];
    assign data  = data_q[idx];
endmodule

// File: rtl/cache_controller.sv
// cache_controller: 2-way set-associative write-through, no-write-allocate data cache
// Ports: clk, rst (async active-low); MEM side rd_en/wr_en/address/write_data -> read_data/freeze;
//        SRAM side sram_rd_en/sram_wr_en/sram_address/sram_write_data <- sram_read_data/sram_ready.
module cache_controller
    import cache_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        freeze,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_write_data,
    input  logic [31:0] sram_read_data,
    input  logic        sram_ready
);
    localparam logic [16:0] BASE_W = BASE_ADDR[18:2];

    state_t              state, next_state;
    logic [SETS-1:0]     lru;
    logic [16:0]         offs_w;
    logic [SET_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag, tag0, tag1;
    logic [31:0]         data0, data1, wdata;
    logic                valid0, valid1, hit0, hit1, hit, victim;
    logic                fill, wr_hit, rd_hit, we0, we1;

    // Address is word aligned, so the offset subtraction only needs the word-index bits.
    assign offs_w = address[18:2] - BASE_W;
    assign idx    = offs_w[SET_BITS-1:0];
    assign tag    = offs_w[16:SET_BITS];

    assign hit0   = valid0 && tag0 == tag;
    assign hit1   = valid1 && tag1 == tag;
    assign hit    = hit0 || hit1;
    assign victim = lru[idx];

    assign fill   = state == RD_MISS && sram_ready;
    assign wr_hit = state == WR_THRU && sram_ready && hit;
    assign rd_hit = state == IDLE && rd_en && hit;
    assign we0    = (fill && !victim) || (wr_hit && hit0);
    assign we1    = (fill && victim) || (wr_hit && !hit0);
    assign wdata  = fill ? sram_read_data : write_data;

    cache_way u_way0 (
        .clk(clk), .rst(rst), .we(we0), .idx(idx), .wtag(tag), .wdata(wdata),
        .valid(valid0), .tag(tag0), .data(data0)
    );
    cache_way u_way1 (
        .clk(clk), .rst(rst), .we(we1), .idx(idx), .wtag(tag), .wdata(wdata),
        .valid(valid1), .tag(tag1), .data(data1)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= next_state;

    // lru points at the victim: a hit in way0 makes way1 the victim and vice versa.
    always_ff @(posedge clk or negedge rst)
        if (!rst) lru <= '0;
        else if (rd_hit || wr_hit) lru[idx] <= hit0;
        else if (fill) lru[idx] <= !victim;

    // rd_en wins over wr_en when both are asserted.
    always_comb begin
        next_state = state;
        next_state = state == IDLE ? (rd_en ? (hit ? IDLE : RD_MISS) : (wr_en ? WR_THRU : IDLE))
                                   : (sram_ready ? IDLE : state);
    end

    // freeze is gated by rst so an asserted reset drops it even while the request is held.
    assign freeze          = rst && (state == IDLE ? (rd_en ? !hit : wr_en) : !sram_ready);
    assign sram_rd_en      = state == RD_MISS;
    assign sram_wr_en      = state == WR_THRU;
    assign sram_address    = address;
    assign sram_write_data = write_data;
    assign read_data       = fill ? sram_read_data : hit0 ? data0 : hit1 ? data1 : 32'd0;
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed table-driven bench for cache_controller with a 5-cycle SRAM model
module tb_cache_controller;
    logic        clk = 1'b0, rst = 1'b1, rd_en = 1'b0, wr_en = 1'b0, sram_ready = 1'b0;
    logic [31:0] address = '0, write_data = '0;
    logic [31:0] read_data, sram_address, sram_write_data, sram_read_data;
    logic        freeze, sram_rd_en, sram_wr_en;
    logic [31:0] wmem [0:1023];
    bit   [1023:0] wv;
    int          cnt;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .read_data(read_data), .freeze(freeze),
        .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_address(sram_address),
        .sram_write_data(sram_write_data), .sram_read_data(sram_read_data), .sram_ready(sram_ready)
    );

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a == 32'h400 ? 32'hDEADBEEF : {{4{a[11:8]}}, a[15:0]};
    endfunction

    assign sram_read_data = wv[sram_address[11:2]] ? wmem[sram_address[11:2]] : dflt(sram_address);

    always @(posedge clk) begin
        if (!rst) begin
            cnt <= 0;
            sram_ready <= 1'b0;
        end else if ((sram_rd_en || sram_wr_en) && !sram_ready) begin
            if (cnt == 4) begin
                sram_ready <= 1'b1;
                cnt <= 0;
                if (sram_wr_en) begin
                    wmem[sram_address[11:2]] <= sram_write_data;
                    wv[sram_address[11:2]] <= 1'b1;
                end
            end else cnt <= cnt + 1;
        end else sram_ready <= 1'b0;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    task automatic do_reset();
        rd_en = 1'b0;
        wr_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("reset freeze", 32'(freeze), 0);
        chk("reset sram_en", {30'd0, sram_rd_en, sram_wr_en}, 0);
        chk("reset read_data", read_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Called at a negedge; holds the request until freeze drops, then releases it after one edge.
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int cyc, output logic [31:0] rdat, output int nrd, output int nwr,
                          output logic [1:0] post);
        rd_en = r;
        wr_en = w;
        address = a;
        write_data = d;
        cyc = 0;
        nrd = 0;
        nwr = 0;
        #1;
        while (freeze && cyc < 50) begin
            @(negedge clk);
            cyc++;
            nrd += int'(sram_rd_en);
            nwr += int'(sram_wr_en);
        end
        rdat = read_data;
        @(posedge clk);
        #1 post = {sram_rd_en, sram_wr_en};
        @(negedge clk);
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    typedef struct {
        bit          rf;
        bit          r;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        int          cyc;
        logic [31:0] rd;
        bit          er;
        bit          ew;
    } vec_t;

    vec_t        v [15];
    int          cyc, nrd, nwr;
    logic [31:0] rdat;
    logic [1:0]  post;

    initial begin
        v[0]  = '{1, 1, 0, 32'h400, 32'h0,        6, 32'hDEADBEEF, 1, 0};
        v[1]  = '{0, 1, 0, 32'h400, 32'h0,        0, 32'hDEADBEEF, 0, 0};
        v[2]  = '{0, 0, 1, 32'h404, 32'h12345678, 6, 32'h0,        0, 1};
        v[3]  = '{0, 1, 0, 32'h404, 32'h0,        6, 32'h12345678, 1, 0};
        v[4]  = '{1, 1, 0, 32'h400, 32'h0,        6, 32'hDEADBEEF, 1, 0};
        v[5]  = '{0, 0, 1, 32'h400, 32'hCAFEF00D, 6, 32'h0,        0, 1};
        v[6]  = '{0, 1, 0, 32'h400, 32'h0,        0, 32'hCAFEF00D, 0, 0};
        v[7]  = '{1, 1, 0, 32'h400, 32'h0,        6, 32'hCAFEF00D, 1, 0};
        v[8]  = '{0, 1, 0, 32'h500, 32'h0,        6, 32'h55550500, 1, 0};
        v[9]  = '{0, 1, 0, 32'h400, 32'h0,        0, 32'hCAFEF00D, 0, 0};
        v[10] = '{0, 1, 0, 32'h600, 32'h0,        6, 32'h66660600, 1, 0};
        v[11] = '{0, 1, 0, 32'h400, 32'h0,        0, 32'hCAFEF00D, 0, 0};
        v[12] = '{0, 1, 0, 32'h500, 32'h0,        6, 32'h55550500, 1, 0};
        v[13] = '{1, 1, 1, 32'h408, 32'hBAD0BAD0, 6, 32'h44440408, 1, 0};
        v[14] = '{0, 1, 0, 32'h408, 32'h0,        0, 32'h44440408, 0, 0};
        for (int i = 0; i < 15; i++) begin
            if (v[i].rf) do_reset();
            access(v[i].r, v[i].w, v[i].a, v[i].d, cyc, rdat, nrd, nwr, post);
            chk($sformatf("v%0d stall_cycles", i), 32'(cyc), 32'(v[i].cyc));
            if (v[i].r) chk($sformatf("v%0d read_data", i), rdat, v[i].rd);
            chk($sformatf("v%0d sram_rd_seen", i), 32'(nrd != 0), 32'(v[i].er));
            chk($sformatf("v%0d sram_wr_seen", i), 32'(nwr != 0), 32'(v[i].ew));
            chk($sformatf("v%0d sram_en_after", i), 32'(post), 0);
        end
        do_reset();
        rd_en = 1'b1;
        address = 32'h400;
        repeat (3) @(negedge clk);
        chk("midreset rd_en_before", {30'd0, sram_rd_en, freeze}, 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("midreset rd_en_async", 32'(sram_rd_en), 0);
        chk("midreset freeze_async", 32'(freeze), 0);
        rd_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        access(1'b1, 1'b0, 32'h400, 32'h0, cyc, rdat, nrd, nwr, post);
        chk("midreset reread_cycles", 32'(cyc), 6);
        chk("midreset reread_sram_rd", 32'(nrd != 0), 1);
        chk("midreset reread_data", rdat, 32'hCAFEF00D);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
